// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the core's single external memory port between the icache refill
// path and the dcache refill/writeback path. A request seen while idle wins
// a grant that stays locked to that requester until the external memory
// acknowledges. The completion pulse goes only to the owner. One idle cycle
// always separates two consecutive grants.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   - on a tie, grant the port that did not own the bus last
//   undefined - fixed priority, the dcache wins every tie
//
// Parameters:
//   ADDR_W               address width
//   LINE_W               cache line width in bits
//
// Ports:
//   clk                  core clock
//   rst                  synchronous active-high reset
//   i_addr_valid/i_addr  icache line read request, held until i_done
//   i_done               one-cycle completion pulse to the icache
//   d_addr_valid/d_addr  dcache request, held until d_done
//   d_write_data_valid   dcache request is a write
//   d_write_data         dcache write line
//   d_done               one-cycle completion pulse to the dcache
//   rd_data              external read line, forwarded to both caches
//   ext_addr_valid       address valid to external memory
//   ext_addr             address to external memory
//   ext_write_data_valid write strobe to external memory
//   ext_write_data       write line to external memory
//   ext_read_data_ready  external completion acknowledge (read or write)
//   ext_read_data        external read line
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_addr_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    input  logic              d_addr_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_write_data_valid,
    input  logic [LINE_W-1:0] d_write_data,
    output logic              d_done,
    output logic [LINE_W-1:0] rd_data,
    output logic              ext_addr_valid,
    output logic [ADDR_W-1:0] ext_addr,
    output logic              ext_write_data_valid,
    output logic [LINE_W-1:0] ext_write_data,
    input  logic              ext_read_data_ready,
    input  logic [LINE_W-1:0] ext_read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_t;

    state_t state;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Most recent owner: 0 = icache, 1 = dcache. Reset to 1 so the icache
    // wins the first tie.
    logic last;
`endif

    // Grant FSM. A grant is only issued from IDLE and is only released by
    // the external acknowledge, so the other port can never preempt an
    // owner, and returning to IDLE forces the turnaround cycle between
    // grants. An acknowledge arriving in IDLE is simply ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_addr_valid && d_addr_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        state <= last ? OWN_I : OWN_D;
`else
                        state <= OWN_D;
`endif
                    end else if (i_addr_valid) begin
                        state <= OWN_I;
                    end else if (d_addr_valid) begin
                        state <= OWN_D;
                    end
                end
                OWN_I: begin
                    if (ext_read_data_ready) begin
                        state <= IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last  <= 1'b0;
`endif
                    end
                end
                OWN_D: begin
                    if (ext_read_data_ready) begin
                        state <= IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last  <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output steering. Outputs follow the owner's live request, so an owner
    // that drops valid early only drops ext_addr_valid while the grant is
    // held. The done pulse is combinational with the acknowledge so the
    // cache can release valid on the following edge. Everything is forced
    // to zero while rst is high, since the registered state may still show
    // an owner during the reset cycle itself.
    always_comb begin
        ext_addr_valid       = 1'b0;
        ext_addr             = '0;
        ext_write_data_valid = 1'b0;
        ext_write_data       = '0;
        i_done               = 1'b0;
        d_done               = 1'b0;
        if (!rst) begin
            case (state)
                OWN_I: begin
                    ext_addr_valid = i_addr_valid;
                    ext_addr       = i_addr;
                    i_done         = ext_read_data_ready;
                end
                OWN_D: begin
                    ext_addr_valid       = d_addr_valid;
                    ext_addr             = d_addr;
                    ext_write_data_valid = d_addr_valid & d_write_data_valid;
                    ext_write_data       = d_write_data;
                    d_done               = ext_read_data_ready;
                end
                default: begin
                    ext_addr_valid = 1'b0;
                end
            endcase
        end
    end

    assign rd_data = ext_read_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A directed vector table covers
// single reads, writes, locking, early valid drop, stray acknowledges and
// reset during ownership; a contention sequence checks the tie-break order;
// a randomized phase compares every cycle against a behavioural model that
// tracks who owns the port and which port owned it last.
// Honours MEM_ARB_ROUND_ROBIN_EN for the tie-break expectations.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 512;

    logic              clk;
    logic              rst;
    logic              i_addr_valid;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic              d_addr_valid;
    logic [ADDR_W-1:0] d_addr;
    logic              d_write_data_valid;
    logic [LINE_W-1:0] d_write_data;
    logic              d_done;
    logic [LINE_W-1:0] rd_data;
    logic              ext_addr_valid;
    logic [ADDR_W-1:0] ext_addr;
    logic              ext_write_data_valid;
    logic [LINE_W-1:0] ext_write_data;
    logic              ext_read_data_ready;
    logic [LINE_W-1:0] ext_read_data;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_addr_valid        (i_addr_valid),
        .i_addr              (i_addr),
        .i_done              (i_done),
        .d_addr_valid        (d_addr_valid),
        .d_addr              (d_addr),
        .d_write_data_valid  (d_write_data_valid),
        .d_write_data        (d_write_data),
        .d_done              (d_done),
        .rd_data             (rd_data),
        .ext_addr_valid      (ext_addr_valid),
        .ext_addr            (ext_addr),
        .ext_write_data_valid(ext_write_data_valid),
        .ext_write_data      (ext_write_data),
        .ext_read_data_ready (ext_read_data_ready),
        .ext_read_data       (ext_read_data)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Behavioural model: current owner (0 none, 1 icache, 2 dcache) and
    // most recent owner (0 icache, 1 dcache).
    int m_owner = 0;
    int m_last  = 1;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic        dwv;
        logic        ack;
        logic        e_av;
        logic [31:0] e_addr;
        logic        e_wdv;
        logic        e_idone;
        logic        e_ddone;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic r, logic iv, logic [31:0] ia, logic dv,
                                 logic [31:0] da, logic dwv, logic ack,
                                 logic e_av, logic [31:0] e_addr, logic e_wdv,
                                 logic e_idone, logic e_ddone);
        vec_t v;
        v.rst = r;       v.iv = iv;       v.ia = ia;
        v.dv = dv;       v.da = da;       v.dwv = dwv;
        v.ack = ack;     v.e_av = e_av;   v.e_addr = e_addr;
        v.e_wdv = e_wdv; v.e_idone = e_idone; v.e_ddone = e_ddone;
        return v;
    endfunction

    function automatic logic [LINE_W-1:0] randLine();
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_W / 32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                               input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Drives one cycle of inputs just after a rising edge, checks all outputs
    // against the model mid-cycle, then advances the model to what the next
    // rising edge should do with these inputs.
    task automatic applyStimulus(input logic r, input logic iv, input logic [31:0] ia,
                                 input logic dv, input logic [31:0] da, input logic dwv,
                                 input logic [LINE_W-1:0] dwd, input logic ack,
                                 input logic [LINE_W-1:0] rdat);
        logic              e_av, e_wdv, e_id, e_dd;
        logic [31:0]       e_addr;
        logic [LINE_W-1:0] e_wd;
        @(posedge clk);
        #1;
        rst = r;
        i_addr_valid = iv;
        i_addr = ia;
        d_addr_valid = dv;
        d_addr = da;
        d_write_data_valid = dwv;
        d_write_data = dwd;
        ext_read_data_ready = ack;
        ext_read_data = rdat;
        @(negedge clk);

        e_av = 0; e_wdv = 0; e_id = 0; e_dd = 0; e_addr = 0; e_wd = '0;
        if (!r && m_owner == 1) begin
            e_av = iv; e_addr = ia; e_id = ack;
        end else if (!r && m_owner == 2) begin
            e_av = dv; e_addr = da; e_wdv = dv & dwv; e_wd = dwd; e_dd = ack;
        end
        checkOutput("model_ext_addr_valid", ext_addr_valid, e_av);
        checkOutput("model_ext_addr", ext_addr, e_addr);
        checkOutput("model_ext_write_data_valid", ext_write_data_valid, e_wdv);
        checkOutput("model_ext_write_data", ext_write_data, e_wd);
        checkOutput("model_i_done", i_done, e_id);
        checkOutput("model_d_done", d_done, e_dd);
        checkOutput("model_rd_data", rd_data, rdat);

        if (r) begin
            m_owner = 0;
            m_last  = 1;
        end else if (m_owner == 0) begin
            if (iv && dv) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                m_owner = (m_last == 1) ? 1 : 2;
`else
                m_owner = 2;
`endif
            end else if (iv) begin
                m_owner = 1;
            end else if (dv) begin
                m_owner = 2;
            end
        end else if (ack) begin
            m_last  = (m_owner == 1) ? 0 : 1;
            m_owner = 0;
        end
    endtask

    // Safety net against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [LINE_W-1:0] beef;
        int                seq[$];
        logic              prev_av;
        logic              prev_ack;
        logic              ack;
        int                exp_id;
        beef = {16{32'hDEADBEEF}};

        rst = 1'b1;
        i_addr_valid = 0; i_addr = 0; d_addr_valid = 0; d_addr = 0;
        d_write_data_valid = 0; d_write_data = '0;
        ext_read_data_ready = 0; ext_read_data = '0;

        // rst iv ia  dv da  dwv ack | av addr wdv idone ddone
        vecs.push_back(mkv(1,0,32'h0,  0,32'h0,   0,0, 0,32'h0,   0,0,0)); // reset cycle
        vecs.push_back(mkv(0,0,32'h0,  0,32'h0,   0,0, 0,32'h0,   0,0,0)); // cycle after reset
        vecs.push_back(mkv(0,1,32'h100,0,32'h0,   0,0, 0,32'h0,   0,0,0)); // I request seen in IDLE
        vecs.push_back(mkv(0,1,32'h100,0,32'h0,   0,0, 1,32'h100, 0,0,0));
        vecs.push_back(mkv(0,1,32'h100,0,32'h0,   0,0, 1,32'h100, 0,0,0));
        vecs.push_back(mkv(0,1,32'h100,0,32'h0,   0,0, 1,32'h100, 0,0,0));
        vecs.push_back(mkv(0,1,32'h100,0,32'h0,   0,1, 1,32'h100, 0,1,0)); // ack 3 cycles on
        vecs.push_back(mkv(0,0,32'h0,  0,32'h0,   0,0, 0,32'h0,   0,0,0));
        vecs.push_back(mkv(0,0,32'h0,  1,32'h2040,1,0, 0,32'h0,   0,0,0)); // D write
        vecs.push_back(mkv(0,0,32'h0,  1,32'h2040,1,0, 1,32'h2040,1,0,0));
        vecs.push_back(mkv(0,0,32'h0,  1,32'h2040,1,1, 1,32'h2040,1,0,1));
        vecs.push_back(mkv(0,0,32'h0,  0,32'h0,   0,0, 0,32'h0,   0,0,0));
        vecs.push_back(mkv(0,0,32'h0,  0,32'h0,   0,1, 0,32'h0,   0,0,0)); // stray ack
        vecs.push_back(mkv(0,1,32'h300,0,32'h0,   0,0, 0,32'h0,   0,0,0)); // lock test
        vecs.push_back(mkv(0,1,32'h300,1,32'h400, 0,0, 1,32'h300, 0,0,0));
        vecs.push_back(mkv(0,1,32'h300,1,32'h400, 0,0, 1,32'h300, 0,0,0));
        vecs.push_back(mkv(0,1,32'h300,1,32'h400, 0,1, 1,32'h300, 0,1,0));
        vecs.push_back(mkv(0,0,32'h0,  1,32'h400, 0,0, 0,32'h0,   0,0,0)); // turnaround
        vecs.push_back(mkv(0,0,32'h0,  1,32'h400, 0,0, 1,32'h400, 0,0,0)); // D 2 after ack
        vecs.push_back(mkv(0,0,32'h0,  1,32'h400, 0,1, 1,32'h400, 0,0,1));
        vecs.push_back(mkv(0,0,32'h0,  0,32'h0,   0,0, 0,32'h0,   0,0,0));
        vecs.push_back(mkv(0,1,32'h500,0,32'h0,   0,0, 0,32'h0,   0,0,0)); // early valid drop
        vecs.push_back(mkv(0,0,32'h500,0,32'h0,   0,0, 0,32'h500, 0,0,0));
        vecs.push_back(mkv(0,0,32'h500,0,32'h0,   0,1, 0,32'h500, 0,1,0));
        vecs.push_back(mkv(0,0,32'h0,  0,32'h0,   0,0, 0,32'h0,   0,0,0));
        vecs.push_back(mkv(0,0,32'h0,  1,32'h600, 1,0, 0,32'h0,   0,0,0)); // reset mid OWN_D
        vecs.push_back(mkv(0,0,32'h0,  1,32'h600, 1,0, 1,32'h600, 1,0,0));
        vecs.push_back(mkv(1,0,32'h0,  1,32'h600, 1,0, 0,32'h0,   0,0,0));
        vecs.push_back(mkv(0,0,32'h0,  0,32'h0,   0,1, 0,32'h0,   0,0,0)); // late ack dropped
        vecs.push_back(mkv(0,0,32'h0,  0,32'h0,   0,0, 0,32'h0,   0,0,0));

        $display("[TB] directed vectors: %0d", vecs.size());
        for (int n = 0; n < vecs.size(); n++) begin
            applyStimulus(vecs[n].rst, vecs[n].iv, vecs[n].ia, vecs[n].dv, vecs[n].da,
                          vecs[n].dwv, beef, vecs[n].ack, randLine());
            checkOutput("vec_ext_addr_valid", ext_addr_valid, vecs[n].e_av);
            checkOutput("vec_ext_addr", ext_addr, vecs[n].e_addr);
            checkOutput("vec_ext_write_data_valid", ext_write_data_valid, vecs[n].e_wdv);
            checkOutput("vec_i_done", i_done, vecs[n].e_idone);
            checkOutput("vec_d_done", d_done, vecs[n].e_ddone);
            if (vecs[n].e_wdv)
                checkOutput("vec_ext_write_data", ext_write_data, beef);
        end

        // Sustained contention straight out of reset: both ports keep
        // requesting, memory acknowledges one cycle after address valid.
        $display("[TB] contention sequence");
        applyStimulus(1, 0, 0, 0, 0, 0, '0, 0, '0);
        applyStimulus(1, 0, 0, 0, 0, 0, '0, 0, '0);
        prev_av  = 0;
        prev_ack = 0;
        for (int c = 0; c < 120 && seq.size() < 8; c++) begin
            ack = prev_av && !prev_ack;
            applyStimulus(0, 1, 32'h1000, 1, 32'h2000, 1, beef, ack, randLine());
            if (i_done) seq.push_back(0);
            if (d_done) seq.push_back(1);
            prev_av  = ext_addr_valid;
            prev_ack = ack;
        end
        checkOutput("contention_txn_count", seq.size(), 8);
        for (int k = 0; k < seq.size() && k < 8; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_id = (k % 2 == 0) ? 0 : 1;
`else
            exp_id = 1;
`endif
            checkOutput("contention_grant_order", seq[k], exp_id);
        end

        // Randomized traffic against the model.
        $display("[TB] random phase");
        applyStimulus(1, 0, 0, 0, 0, 0, '0, 0, '0);
        for (int c = 0; c < 600; c++) begin
            applyStimulus(($urandom_range(0, 31) == 0), $urandom_range(0, 1), $urandom,
                          $urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                          randLine(), ($urandom_range(0, 2) == 0), randLine());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
